// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register feeding the register file: load extraction and
// extension, $0 and misaligned-load suppression, forwarding tap, retire counter.
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [2:0]            in_load_type,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic                  flush,
    input  logic                  wb_stall,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  align_err,
    output logic [CNT_W-1:0]      retire_count
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic                  valid_q;
    logic                  rw_q;
    logic                  m2r_q;
    logic [2:0]            lt_q;
    logic [1:0]            alo_q;
    logic [DATA_W-1:0]     alu_q;
    logic [DATA_W-1:0]     mem_q;
    logic [REG_ADDR_W-1:0] wr_q;

    logic                  accept;
    logic                  retire;
    logic                  misaligned;
    logic                  live;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     sel_data;

    // Handshake: a beat transfers on a rising edge when in_valid & in_ready and
    // flush is low; in_ready never depends on in_valid, and flush always
    // reports ready so the offered beat is consumed (and dropped) that cycle.
    assign in_ready = flush | ~valid_q | ~wb_stall;
    assign accept   = in_valid & in_ready & ~flush;
    assign retire   = valid_q & ~wb_stall & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            lt_q    <= '0;
            alo_q   <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            wr_q    <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (retire) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                rw_q  <= in_reg_write;
                m2r_q <= in_mem_to_reg;
                lt_q  <= in_load_type;
                alo_q <= in_addr_lo;
                alu_q <= in_alu_result;
                mem_q <= in_mem_data;
                wr_q  <= in_write_reg;
            end
        end
    end

    // Little-endian lane selection from the raw memory word.
    always_comb begin
        byte_sel = mem_q[7:0];
        case (alo_q)
            2'd0: byte_sel = mem_q[7:0];
            2'd1: byte_sel = mem_q[15:8];
            2'd2: byte_sel = mem_q[23:16];
            2'd3: byte_sel = mem_q[31:24];
            default: byte_sel = mem_q[7:0];
        endcase
    end

    assign half_sel = alo_q[1] ? mem_q[31:16] : mem_q[15:0];

    always_comb begin
        load_data = mem_q;
        case (lt_q)
            LT_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LT_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_data = mem_q;
        endcase
    end

    // Undefined load types behave as LW, including the word alignment rule.
    always_comb begin
        misaligned = 1'b0;
        if (m2r_q) begin
            case (lt_q)
                LT_LB, LT_LBU: misaligned = 1'b0;
                LT_LH, LT_LHU: misaligned = alo_q[0];
                default:       misaligned = (alo_q != 2'd0);
            endcase
        end
    end

    assign sel_data = m2r_q ? load_data : alu_q;

    assign live       = valid_q & rw_q & (wr_q != '0) & ~misaligned;
    assign reg_write  = live & ~wb_stall & ~flush;
    assign align_err  = valid_q & rw_q & misaligned & ~wb_stall & ~flush;
    assign write_reg  = valid_q ? wr_q : '0;
    assign write_data = valid_q ? sel_data : '0;
    assign fwd_valid  = live & ~flush;
    assign fwd_reg    = write_reg;
    assign fwd_data   = write_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_count <= '0;
        end else if (reg_write) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    // Keeps the unused LW/LT_LW name referenced for readers of the decode table.
    logic lt_is_lw;
    assign lt_is_lw = (lt_q == LT_LW);
    logic unused_ok;
    assign unused_ok = lt_is_lw;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/write-back pipeline stage directly upstream of the MIPS register file.
- Holds one in-flight instruction result in a single-entry pipeline register with a valid/ready handshake.
- Drives the register file's reg_write / write_reg / write_data inputs.
- Performs load-data extraction and extension (LW/LB/LBU/LH/LHU), suppresses writes to $0 and misaligned loads, and exports a forwarding tap and a retire counter.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of retire_count.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream MEM stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 = result from memory data, 0 = ALU result.
- in_load_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others treated as LW.
- in_addr_lo  in  2  low two bits of the load address.
- in_alu_result  in  DATA_W  ALU result.
- in_mem_data  in  DATA_W  raw 32-bit word read from data memory.
- in_write_reg  in  REG_ADDR_W  destination register.
- flush  in  1  discard held entry and any entry offered this cycle.
- wb_stall  in  1  hazard unit holds the entry; no write this cycle.
- reg_write  out  1  to register file write enable.
- write_reg  out  REG_ADDR_W  to register file write address.
- write_data  out  DATA_W  to register file write data.
- fwd_valid  out  1  held entry will produce a register write.
- fwd_reg  out  REG_ADDR_W  forwarding destination.
- fwd_data  out  DATA_W  forwarding value; same as write_data.
- align_err  out  1  one-cycle pulse: misaligned load retired and suppressed.
- retire_count  out  CNT_W  number of committed register writes.

Behaviour:
- Reset (async, reset_n=0):
  - State: valid_q=0, all held fields 0, retire_count=0.
  - Outputs: reg_write=0, write_reg=0, write_data=0, fwd_valid=0, fwd_reg=0, fwd_data=0, align_err=0, in_ready=1.
- Reset mid-operation discards the held entry immediately. No write is issued in that cycle or afterwards until new data is accepted.
- Handshake:
  - in_ready = !valid_q | !wb_stall, forced to 1 while flush=1.
  - Accept on a rising edge when in_valid & in_ready & !flush. All in_* fields are registered.
- Retire: the held entry retires in any cycle with valid_q & !wb_stall & !flush.
  - valid_q at the next edge = accept ? 1 : (retire ? 0 : valid_q).
  - Back-to-back: retire and accept in the same cycle gives one instruction per cycle with no bubble.
- Latency: one instruction per cycle.
  - An entry accepted at edge N drives reg_write during cycle N..N+1 if wb_stall=0.
  - While stalled, the entry holds and reg_write=0.
- Data select (combinational from held fields):
  - in_mem_to_reg=0: write_data = alu_result.
  - in_mem_to_reg=1, extraction from the little-endian word:
    - LW: the whole word.
    - LB/LBU: byte addr_lo, bits [8k+7:8k], sign- or zero-extended.
    - LH/LHU: half addr_lo[1], sign- or zero-extended.
- Misaligned loads (flagged only when mem_to_reg=1):
  - LW with addr_lo!=0 is misaligned.
  - LH/LHU with addr_lo[0]=1 is misaligned.
  - Byte loads are never misaligned.
- Write enable: reg_write = valid_q & rw_q & (write_reg!=0) & !misaligned & !wb_stall & !flush.
  - write_reg and write_data always reflect the held entry, or 0 when valid_q=0.
- align_err = valid_q & rw_q & misaligned & !wb_stall & !flush. It pulses once per offending entry, in its retire cycle.
- fwd_valid = valid_q & rw_q & (write_reg!=0) & !misaligned. It is independent of wb_stall and forced to 0 by flush. fwd_reg = write_reg, fwd_data = write_data.
- Flush:
  - Combinationally forces reg_write, align_err and fwd_valid to 0.
  - Clears valid_q at the next edge.
  - Takes priority over accept and retire.
- retire_count increments by 1 on every cycle with reg_write=1. It wraps from 2^CNT_W−1 to 0.
- Simultaneous wb_stall and flush: flush wins and the entry is dropped.

Test Plan:
- Reset with an entry held → all outputs 0, in_ready=1, retire_count=0; release reset, no spurious reg_write.
- Three back-to-back ALU ops to $9,$10,$11 with data 0x11,0x22,0x33 → reg_write high three consecutive cycles, write_data matches, retire_count=3.
- Loads from mem word 0x80FF7F01:
  - LB addr_lo=3 → 0xFFFFFF80.
  - LBU addr_lo=1 → 0x0000007F.
  - LH addr_lo=2 → 0xFFFF80FF.
  - LHU addr_lo=0 → 0x00007F01.
  - LW addr_lo=0 → 0x80FF7F01.
- LW addr_lo=2 and LH addr_lo=1 → no reg_write, align_err one-cycle pulse each, fwd_valid=0, retire_count unchanged.
- Write to $0 with data 0xDEADBEEF → reg_write=0, fwd_valid=0; wb_stall held 3 cycles on a $12 write → reg_write=0 for 3 cycles, in_ready=0, fwd_valid=1, then a single write.
- Flush with a held entry plus in_valid=1 → neither writes, valid_q=0 next cycle; retire_count preset near 0xFFFF with two writes → wraps to 0x0001.
